// File: rtl/pc_branch_sequencer.sv
// rtl/pc_branch_sequencer.sv - program counter / branch sequencer with link register and flush window
// Optional macro PCSEQ_RETURN_EN adds the i_ret port (pc <= link return).
module pc_branch_sequencer #(
  parameter int              PC_W      = 8,
  parameter int              OFF_W     = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              FLUSH_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_instr_valid,
  input  logic             i_stall,
  input  logic [OFF_W-1:0] i_offset,
  input  logic             i_bccout,
  input  logic             i_bcsout,
  input  logic             i_bneout,
  input  logic             i_beqout,
  input  logic             i_bal,
`ifdef PCSEQ_RETURN_EN
  input  logic             i_ret,
`endif
  output logic [PC_W-1:0]  o_pc,
  output logic [PC_W-1:0]  o_link,
  output logic             o_flush,
  output logic             o_redirect
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_link;
  logic             r_flush;
  logic             r_redirect;

  state_t           w_state_nxt;
  logic [3:0]       w_cnt_nxt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_link_nxt;
  logic             w_flush_nxt;
  logic             w_redirect_nxt;

  logic             w_accept;
  logic             w_take;
  logic             w_ret;
  logic             w_redir_req;
  logic [PC_W-1:0]  w_off_ext;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_inc;

`ifdef PCSEQ_RETURN_EN
  assign w_ret = i_ret;
`else
  assign w_ret = 1'b0;
`endif

  assign w_accept    = i_instr_valid & ~i_stall & (r_state == S_RUN);
  assign w_take      = i_bccout | i_bcsout | i_bneout | i_beqout | i_bal;
  assign w_redir_req = w_accept & (w_take | w_ret);
  assign w_off_ext   = PC_W'($signed(i_offset));
  assign w_target    = r_pc + w_off_ext;
  assign w_pc_inc    = r_pc + PC_W'(1);

  // Stall freezes everything except redirect, which must never outlive its cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_RUN;
      r_cnt      <= '0;
      r_pc       <= RESET_VEC;
      r_link     <= '0;
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
    end else if (!i_stall) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_link     <= w_link_nxt;
      r_flush    <= w_flush_nxt;
      r_redirect <= w_redirect_nxt;
    end else begin
      r_redirect <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_redir_req) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_FLUSH: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RUN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // A taken branch beats a return when both arrive together.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_link_nxt     = r_link;
    w_flush_nxt    = (w_state_nxt == S_FLUSH);
    w_redirect_nxt = w_redir_req;
    if (w_accept) begin
      if (w_take)     w_pc_nxt = w_target;
      else if (w_ret) w_pc_nxt = r_link;
      else            w_pc_nxt = w_pc_inc;
      if (i_bal)      w_link_nxt = w_pc_inc;
    end
  end

  assign o_pc       = r_pc;
  assign o_link     = r_link;
  assign o_flush    = r_flush;
  assign o_redirect = r_redirect;

endmodule

// File: doc/pc_branch_sequencer.md
Name: pc_branch_sequencer

Overview:
- Program-counter sequencer sitting directly downstream of the instruction decoder's branch-detect stage.
- Consumes its per-condition taken strobes (bcc/bcs/bne/beq/BAL) plus the instruction's 8-bit offset field.
- Produces the next fetch address, a link register for branch-and-link, and a pipeline flush window after any taken branch.
- Feeds the instruction memory address port and the fetch/decode valid gating.

Parameters:
PC_W, 8, program counter and link register width
OFF_W, 8, branch offset width (instruction bits [7:0]), two's complement
RESET_VEC, 0, PC value after reset
FLUSH_CYC, 2, cycles of flush asserted after a taken branch (legal 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  decoded instruction and strobes valid this cycle
stall  in  1  hold request from downstream; freezes all state
offset  in  OFF_W  branch offset from instruction [7:0]
bccout  in  1  branch-if-carry-clear taken
bcsout  in  1  branch-if-carry-set taken
bneout  in  1  branch-if-not-equal taken
beqout  in  1  branch-if-equal taken
BAL  in  1  branch-and-link (unconditional)
pc  out  PC_W  current fetch address
link  out  PC_W  saved return address
flush  out  1  discard in-flight fetched/decoded instruction
redirect  out  1  one-cycle pulse: PC loaded with branch target this edge

Behaviour:
- One clock domain, clk; reset is synchronous, active-high, on rst. All outputs registered.
- Reset values: pc=RESET_VEC, link=0, flush=0, redirect=0, state=RUN, flush counter=0. rst has priority over stall and every other input, including mid-FLUSH.
- Accept condition: accept = instr_valid & ~stall & (state==RUN). Strobes are ignored unless accept is high, so stale strobe values from the decoder have no effect.
- take = bccout | bcsout | bneout | beqout | BAL.
- Target: pc + sign_extend(offset, OFF_W -> PC_W), modulo 2^PC_W. Wrap both directions, no saturation. Example: 8'hFF + 1 = 8'h00; 8'h02 + 8'hFC = 8'hFE.
- States:
  - RUN:
    - accept & ~take: pc <= pc+1 (mod 2^PC_W).
    - accept & take: pc <= target; redirect=1 next cycle; flush=1; counter <= FLUSH_CYC-1; go to FLUSH.
    - accept & BAL: additionally link <= pc+1. Link is written only by BAL.
    - ~accept: pc holds.
  - FLUSH:
    - flush=1 and instr_valid ignored; pc holds.
    - Each non-stalled cycle: if counter==0, go to RUN with flush=0 on the next cycle; else counter decrements.
- Multiple strobes high together: one redirect to the same target; link written iff BAL is set. No error.
- Stall:
  - Freezes pc, link, state, counter and flush.
  - redirect is a pulse only and is 0 on any cycle following a stalled cycle.
- Latency:
  - Taken branch accepted at edge N: pc=target and redirect=1 after edge N.
  - flush high for exactly FLUSH_CYC non-stalled cycles starting after edge N.
  - First accept again possible at edge N+FLUSH_CYC+1.

Optional Feature:
- Macro: PCSEQ_RETURN_EN.
- Defined:
  - Adds input port ret (1 bit).
  - accept & ret & ~take: pc <= link, redirect and flush behave as for a taken branch, link unchanged.
  - ret with any take strobe: the branch wins, ret is ignored.
- Undefined:
  - No ret port; link is observable only and never reloaded into pc.

Test Plan:
- Reset then 3 accepted non-branch instrs, RESET_VEC=0 -> pc 0,1,2,3; flush=0, redirect=0 throughout.
- pc=8'h10, accept beqout=1, offset=8'h05 -> pc=8'h15, redirect=1 for one cycle, flush=1 for 2 cycles; instr_valid during flush ignored (pc stays 8'h15); accept resumes on the third cycle.
- pc=8'h20, accept BAL=1, offset=8'hF0 -> pc=8'h10, link=8'h21. A following bneout branch leaves link=8'h21.
- pc=8'hFE, accept bccout, offset=8'h03 -> pc=8'h01 (wrap). Non-branch at pc=8'hFF -> pc=8'h00.
- Taken branch then stall=1 for 3 cycles inside FLUSH -> flush stays 1 and the counter is frozen. Flush deasserts only after 2 non-stalled cycles. rst mid-FLUSH -> pc=RESET_VEC, flush=0 next cycle.
- With PCSEQ_RETURN_EN, link=8'h21 and pc=8'h40: accept ret -> pc=8'h21, flush 2 cycles. ret together with bcsout (offset 8'h02) -> pc=8'h42.
